sistema_x_driver: RTL and testbench
===================================

Name: sistema_x_driver

Overview:
- Self-test driver for the 4-bit constant comparator; it sits on the opposite side of the comparator's X/Q interface.
- Sweeps X through all 2^WIDTH codes, waits a settle interval for the gate-level comparator, and samples Q.
- Checks Q against the expected value (X == MATCH_VALUE), counts matches, and records the first mismatching code.
- Used in the gate-level test harness; results are read by the bench or a status register.

Parameters:
- WIDTH, 4, width of the driven code X.
- MATCH_VALUE, 4'b0101, code on which Q is expected high.
- SETTLE_CYCLES, 2, clock cycles X is held before Q is sampled; legal range is >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a sweep; sampled only in IDLE or DONE.
- abort  input  1  synchronous abort; returns to IDLE.
- x_out  output  WIDTH  code driven onto the comparator's X input.
- q_in  input  1  comparator's Q output.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or abort.
- pass  output  1  valid when done is high; 1 if no mismatch was found.
- match_count  output  WIDTH+1  number of codes for which q_in was sampled as 1.
- fail_valid  output  1  a mismatch has been recorded in this sweep.
- fail_value  output  WIDTH  x_out value at the first mismatch.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, x_out=0, busy=0, done=0, pass=0, match_count=0, fail_valid=0, fail_value=0. Outputs change immediately on reset assertion, including mid-sweep.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE/DONE with start=1 and abort=0, at edge k:
  - go to DRIVE; x_out<=0; settle_cnt<=0.
  - busy<=1, done<=0, pass<=1, match_count<=0, fail_valid<=0, fail_value<=0.
- DRIVE: settle_cnt increments each edge. On the edge where settle_cnt==SETTLE_CYCLES-1, go to CHECK.
- CHECK: q_in is sampled on the edge leaving CHECK; expected = (x_out==MATCH_VALUE).
  - If q_in=1, match_count increments.
  - If q_in!=expected and fail_valid=0: fail_value<=x_out, fail_valid<=1, pass<=0. Later mismatches do not overwrite fail_value.
  - If x_out==2^WIDTH-1: go to DONE; busy<=0, done<=1; x_out holds its value.
  - Otherwise: x_out increments, settle_cnt<=0, go to DRIVE.
- Timing:
  - Each code occupies SETTLE_CYCLES+1 cycles; x_out is stable for that whole window.
  - Full sweep = 2^WIDTH*(SETTLE_CYCLES+1) cycles. With defaults, done rises at edge k+48.
- x_out changes only on edges leaving CHECK or on edge k; it never glitches mid-window.
- start while busy is ignored.
- DONE holds all results until the next start or abort.
- abort=1, any state: on the next edge go to IDLE; x_out<=0, busy<=0, done<=0, pass<=0. match_count, fail_valid and fail_value are cleared.
- start and abort high on the same edge: abort wins and the state is IDLE.
- match_count width WIDTH+1 holds 2^WIDTH without wrap.
- q_in is treated as already synchronous: it comes from a combinational path off x_out, so no synchronizer is needed.

Decomposition:
- Package sistema_x_pkg:
  - state_t enum {IDLE, DRIVE, CHECK, DONE}.
  - Constants X_WIDTH=4 and X_MATCH=4'b0101, shared with the comparator bench.
- Sub-module settle_timer: loadable up-counter with a terminal-count output, parameterised by SETTLE_CYCLES. The FSM, code counter and scoreboard registers stay in the top module.

Test Plan:
- Correct comparator (q_in = x_out==5), defaults, 1-cycle start pulse -> busy=1 for 48 cycles; at edge 48 done=1, pass=1, match_count=1, fail_valid=0, x_out=4'hF.
- q_in stuck at 0 -> done at edge 48; pass=0, match_count=0, fail_valid=1, fail_value=4'h5.
- q_in stuck at 1 -> pass=0, match_count=16, fail_value=4'h0.
- Comparator matching 4'h7 instead of 4'h5 -> match_count=1, fail_value=4'h5 (first mismatch in sweep order), pass=0.
- abort at cycle 10 of a sweep -> next edge busy=0, x_out=0, done=0. Start+abort on the same edge -> stays IDLE. A fresh start then reproduces scenario 1 exactly.
- rst_n low mid-sweep (cycle 20) -> all outputs at reset values without waiting for a clock edge. start pulses during busy are ignored, and the sweep length is still 48 cycles.

Source files
------------

// File: rtl/sistema_x_pkg.sv
// Shared definitions for the constant-comparator self-test slice.
// state_t : sweep controller states
// X_WIDTH : width of the comparator code X
// X_MATCH : code on which the comparator's Q is expected high
package sistema_x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned X_WIDTH = 4;
  localparam logic [X_WIDTH-1:0] X_MATCH = 4'b0101;

endpackage

// File: rtl/settle_timer.sv
// Loadable up-counter timing how long a code has been held on X.
// clk, rst_n : clock, asynchronous active-low reset
// load       : clear the count to zero (wins over en)
// en         : count up by one
// tc         : count has reached SETTLE_CYCLES-1
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/sistema_x_driver.sv
// Self-test driver for the constant comparator: sweeps X over every code, lets the
// comparator settle, samples Q and scores it against (X == MATCH_VALUE).
// clk, rst_n  : clock, asynchronous active-low reset
// start       : begin a sweep (honoured in IDLE/DONE only)
// abort       : synchronous return to IDLE, clears results
// x_out       : code driven onto the comparator's X input
// q_in        : comparator's Q output (combinational off x_out)
// busy, done  : sweep in progress / sweep finished
// pass        : no mismatch seen (valid with done)
// match_count : number of codes for which Q was sampled high
// fail_valid  : a mismatch was recorded; fail_value holds the first mismatching code
module sistema_x_driver
  import sistema_x_pkg::*;
#(
  parameter int unsigned         WIDTH         = X_WIDTH,
  parameter logic [WIDTH-1:0]    MATCH_VALUE   = X_MATCH,
  parameter int unsigned         SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] x_out,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   match_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_value
);

  localparam logic [WIDTH-1:0] XOne  = WIDTH'(1);
  localparam logic [WIDTH:0]   McOne = (WIDTH + 1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             pass_q, pass_d;
  logic [WIDTH:0]   mc_q, mc_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fval_q, fval_d;
  logic             timer_load, timer_en, timer_tc;
  logic             q_expected;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  assign q_expected = (x_q == MATCH_VALUE);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    pass_d     = pass_q;
    mc_d       = mc_q;
    fv_d       = fv_q;
    fval_d     = fval_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      x_d        = '0;
      pass_d     = 1'b0;
      mc_d       = '0;
      fv_d       = 1'b0;
      fval_d     = '0;
      timer_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = DRIVE;
            x_d        = '0;
            pass_d     = 1'b1;
            mc_d       = '0;
            fv_d       = 1'b0;
            fval_d     = '0;
            timer_load = 1'b1;
          end
        end
        DRIVE: begin
          timer_en = 1'b1;
          if (timer_tc) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (q_in) begin
            mc_d = mc_q + McOne;
          end
          // Only the first mismatch in sweep order is kept.
          if ((q_in != q_expected) && !fv_q) begin
            fv_d   = 1'b1;
            fval_d = x_q;
            pass_d = 1'b0;
          end
          if (x_q == '1) begin
            state_d = DONE;
          end else begin
            state_d    = DRIVE;
            x_d        = x_q + XOne;
            timer_load = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      pass_q  <= 1'b0;
      mc_q    <= '0;
      fv_q    <= 1'b0;
      fval_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      pass_q  <= pass_d;
      mc_q    <= mc_d;
      fv_q    <= fv_d;
      fval_q  <= fval_d;
    end
  end

  assign x_out       = x_q;
  assign busy        = (state_q == DRIVE) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign match_count = mc_q;
  assign fail_valid  = fv_q;
  assign fail_value  = fval_q;

endmodule

// File: tb/tb_sistema_x_driver.sv
module tb_sistema_x_driver;

  localparam int Width  = 4;
  localparam int Codes  = 16;
  localparam int Match  = 5;
  localparam int Window = 3;  // SETTLE_CYCLES + 1
  localparam int Sweep  = Codes * Window;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [Width-1:0] x_out;
  logic             q_in;
  logic             busy, done, pass, fail_valid;
  logic [Width:0]   match_count;
  logic [Width-1:0] fail_value;

  // Comparator under test: bit i of qtab is Q when X == i.
  logic [Codes-1:0] qtab = 16'h0020;
  assign q_in = qtab[x_out];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sistema_x_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .x_out      (x_out),
    .q_in       (q_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .match_count(match_count),
    .fail_valid (fail_valid),
    .fail_value (fail_value)
  );

  typedef struct {
    string            name;
    logic [Codes-1:0] tab;
    int               mc;
    bit               pass;
    bit               fv;
    int               fval;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected sweep outcome straight from the scoring rules.
  function automatic void model(input logic [Codes-1:0] t, output int mc, output bit p,
                                output bit fv, output int fval);
    mc = 0; fv = 0; fval = 0;
    for (int i = 0; i < Codes; i++) begin
      if (t[i]) mc++;
      if ((t[i] != (i == Match)) && !fv) begin
        fv = 1; fval = i;
      end
    end
    p = !fv;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_x"}, int'(x_out), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_mc"}, int'(match_count), 0);
    chk({tag, "_fv"}, int'(fail_valid), 0);
    chk({tag, "_fval"}, int'(fail_value), 0);
  endtask

  // Runs one full sweep; pulse_at >= 0 injects start pulses while busy.
  task automatic run_sweep(input string name, input logic [Codes-1:0] t, input int mc,
                           input bit p, input bit fv, input int fval, input int pulse_at);
    int n;
    qtab  = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_start"}, int'(busy), 1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (x_out != Width'(n / Window) || busy !== 1'b1)
        chk({name, "_window"}, int'({busy, x_out}), int'({1'b1, Width'(n / Window)}));
      start = (pulse_at >= 0) && (n == pulse_at || n == pulse_at + 7);
      tick();
      start = 1'b0;
      n++;
    end
    chk({name, "_length"}, n, Sweep);
    chk({name, "_done"}, int'(done), 1);
    chk({name, "_busy_end"}, int'(busy), 0);
    chk({name, "_pass"}, int'(pass), int'(p));
    chk({name, "_mc"}, int'(match_count), mc);
    chk({name, "_fv"}, int'(fail_valid), int'(fv));
    chk({name, "_fval"}, int'(fail_value), fval);
    chk({name, "_x_end"}, int'(x_out), Codes - 1);
    repeat (3) tick();
    chk({name, "_hold"}, int'({done, pass, match_count, fail_valid}),
        int'({1'b1, p, (Width + 1)'(mc), fv}));
  endtask

  vec_t vecs[4];

  initial begin
    int mc, fval;
    bit p, fv;
    logic [Codes-1:0] rt;

    vecs[0] = '{"correct", 16'h0020, 1, 1'b1, 1'b0, 0};
    vecs[1] = '{"stuck0", 16'h0000, 0, 1'b0, 1'b1, 5};
    vecs[2] = '{"stuck1", 16'hFFFF, 16, 1'b0, 1'b1, 0};
    vecs[3] = '{"match7", 16'h0080, 1, 1'b0, 1'b1, 5};

    #12;
    check_idle("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("reset_rel");

    foreach (vecs[i])
      run_sweep(vecs[i].name, vecs[i].tab, vecs[i].mc, vecs[i].pass, vecs[i].fv,
                vecs[i].fval, -1);

    for (int r = 0; r < 6; r++) begin
      rt = Codes'($urandom);
      model(rt, mc, p, fv, fval);
      run_sweep("random", rt, mc, p, fv, fval, -1);
    end

    // Abort in DONE clears results.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_done");

    // Abort ten cycles into a sweep.
    qtab  = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_abort_busy", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_mid");

    // Start and abort together: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort");
    tick();
    check_idle("start_abort_after");

    run_sweep("fresh", 16'h0020, 1, 1'b1, 1'b0, 0, -1);

    // Start pulses while busy are ignored.
    run_sweep("start_busy", 16'h0020, 1, 1'b1, 1'b0, 0, 4);

    // Asynchronous reset mid-sweep, asserted away from any clock edge.
    qtab  = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("pre_reset_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
